lcd_pixel_streamer: RTL

- Initiator side of the pixel update handshake.
- Raster-scans the X_MAX x Y_MAX screen, pulsing update with update_x/update_y to the display buffer updater.
- Captures done_color when done returns and streams each pixel as two bytes, MSB first, to an ST7735-class LCD over 4-wire write-only SPI.
- Sends the window commands (CASET/RASET/RAMWR) before every frame.
- Next-pixel request overlaps the SPI shift of the current pixel.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/spi_byte_tx.sv | 71 +++++++
 rtl/lcd_pixel_streamer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, types and header-byte table for the LCD pixel streamer.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam int unsigned HDR_LEN  = 11;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StStream,
    StLast,
    StGap
  } state_e;

  // Returns {dc, byte} for window-header position idx; commands carry dc=0.
  function automatic logic [8:0] hdr_byte(input logic [3:0] idx, input logic [7:0] x0,
                                          input logic [7:0] x1, input logic [7:0] y0,
                                          input logic [7:0] y1);
    logic [8:0] r;
    case (idx)
      4'd0:    r = {1'b0, CMD_CASET};
      4'd2:    r = {1'b1, x0};
      4'd4:    r = {1'b1, x1};
      4'd5:    r = {1'b0, CMD_RASET};
      4'd7:    r = {1'b1, y0};
      4'd9:    r = {1'b1, y1};
      4'd10:   r = {1'b0, CMD_RAMWR};
      default: r = {1'b1, 8'h00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 write-only SPI byte shifter, MSB first; accepts a new byte on the
// final cycle of the current one so consecutive bytes run without a gap.
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  output logic       o_busy,
  output logic       o_byte_done,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_dc_out
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic            r_busy;
  logic            r_sclk;
  logic            r_dc;
  logic [7:0]      r_sh;
  logic [DivW-1:0] r_div;
  logic [3:0]      r_half;

  logic w_tick;
  logic w_last;
  logic w_load;

  assign w_tick = r_busy && (r_div == DivW'(CLK_DIV - 1));
  assign w_last = w_tick && (r_half == 4'd15);
  assign w_load = i_start && (!r_busy || w_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_dc   <= 1'b0;
      r_sh   <= 8'h00;
      r_div  <= '0;
      r_half <= 4'd0;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_dc   <= i_dc;
      r_sh   <= i_byte;
      r_div  <= '0;
      r_half <= 4'd0;
    end else if (w_last) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_sh   <= 8'h00;
    end else if (w_tick) begin
      r_div  <= '0;
      r_half <= r_half + 4'd1;
      r_sclk <= ~r_sclk;
      // Data moves on the falling edge so it is stable across the next rise.
      if (r_sclk) r_sh <= {r_sh[6:0], 1'b0};
    end else if (r_busy) begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_busy      = r_busy;
  assign o_byte_done = w_last;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_sh[7];
  assign o_dc_out    = r_dc;

endmodule

// File: rtl/lcd_pixel_streamer.sv
// Raster-scans pixels from a display-buffer responder and streams them to an ST7735-class LCD.
// Optional build macro REQ_TIMEOUT_EN substitutes black for a pixel whose done never arrives.
module lcd_pixel_streamer
  import lcd_pkg::*;
#(
  parameter int unsigned X_MAX       = 160,
  parameter int unsigned Y_MAX       = 80,
  parameter int unsigned X_OFS       = 1,
  parameter int unsigned Y_OFS       = 26,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  output logic                     o_update,
  output logic [$clog2(X_MAX):0]   o_update_x,
  output logic [$clog2(Y_MAX):0]   o_update_y,
  input  logic                     i_done,
  input  logic [15:0]              i_done_color,
  output logic                     o_lcd_sclk,
  output logic                     o_lcd_mosi,
  output logic                     o_lcd_dc,
  output logic                     o_lcd_cs,
  output logic                     o_frame_done,
  output logic                     o_err_timeout
);

  localparam int unsigned XW   = $clog2(X_MAX);
  localparam int unsigned YW   = $clog2(Y_MAX);
  localparam int unsigned NPIX = X_MAX * Y_MAX;
  localparam int unsigned CW   = $clog2(NPIX + 1);

  localparam logic [XW:0] X_LAST = (XW + 1)'(X_MAX - 1);
  localparam logic [YW:0] Y_LAST = (YW + 1)'(Y_MAX - 1);
  localparam logic [7:0]  X0     = 8'(X_OFS);
  localparam logic [7:0]  X1     = 8'(X_OFS + X_MAX - 1);
  localparam logic [7:0]  Y0     = 8'(Y_OFS);
  localparam logic [7:0]  Y1     = 8'(Y_OFS + Y_MAX - 1);

  state_e        r_state, w_state_nxt;
  logic [3:0]    r_hdr_idx, w_hdr_idx_nxt;
  logic          r_lo_sel, w_lo_sel_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [CW-1:0] r_req_cnt;
  logic          r_update, r_out, r_buf_full;
  logic [XW:0]   r_x;
  logic [YW:0]   r_y;
  rgb565_t       r_buf;
  logic [7:0]    r_lo_byte;

  logic          w_tx_start, w_tx_dc, w_tx_busy, w_tx_done, w_tx_free, w_buf_pop;
  logic [7:0]    w_tx_byte;
  logic          w_req_ok, w_done_in, w_tmo, w_accept;
  rgb565_t       w_pix_color;

  assign w_tx_free = !w_tx_busy || w_tx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_hdr_idx <= 4'd0;
      r_lo_sel  <= 1'b0;
      r_tx_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hdr_idx <= w_hdr_idx_nxt;
      r_lo_sel  <= w_lo_sel_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_idx_nxt = r_hdr_idx;
    w_lo_sel_nxt  = r_lo_sel;
    w_tx_cnt_nxt  = r_tx_cnt;
    w_tx_start    = 1'b0;
    w_tx_byte     = 8'h00;
    w_tx_dc       = 1'b1;
    w_buf_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        w_hdr_idx_nxt = 4'd0;
        if (i_enable) w_state_nxt = StHdr;
      end
      StHdr: begin
        if (w_tx_free) begin
          w_tx_start             = 1'b1;
          {w_tx_dc, w_tx_byte}   = hdr_byte(r_hdr_idx, X0, X1, Y0, Y1);
          w_hdr_idx_nxt          = r_hdr_idx + 4'd1;
          if (r_hdr_idx == 4'(HDR_LEN - 1)) begin
            w_state_nxt  = StStream;
            w_lo_sel_nxt = 1'b0;
            w_tx_cnt_nxt = '0;
          end
        end
      end
      StStream: begin
        if (w_tx_free) begin
          if (r_lo_sel) begin
            w_tx_start   = 1'b1;
            w_tx_byte    = r_lo_byte;
            w_lo_sel_nxt = 1'b0;
            w_tx_cnt_nxt = r_tx_cnt + 1'b1;
            if (r_tx_cnt == CW'(NPIX - 1)) w_state_nxt = StLast;
          end else if (r_buf_full) begin
            w_tx_start   = 1'b1;
            w_tx_byte    = r_buf[15:8];
            w_buf_pop    = 1'b1;
            w_lo_sel_nxt = 1'b1;
          end
        end
      end
      StLast: begin
        if (w_tx_done) w_state_nxt = StGap;
      end
      StGap: begin
        w_hdr_idx_nxt = 4'd0;
        w_state_nxt   = i_enable ? StHdr : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Requests run only inside a frame and stop once every pixel of it has been asked for.
  assign w_req_ok  = ((r_state == StHdr) || (r_state == StStream)) && !r_out && !r_buf_full &&
                     (r_req_cnt != CW'(NPIX));
  assign w_done_in = i_done && r_out;
  assign w_accept  = w_done_in || w_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_update   <= 1'b0;
      r_out      <= 1'b0;
      r_req_cnt  <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_lo_byte  <= 8'h00;
    end else begin
      r_update <= w_req_ok;
      if (w_req_ok) begin
        r_out     <= 1'b1;
        r_req_cnt <= r_req_cnt + 1'b1;
      end else if ((r_state == StIdle) || (r_state == StGap)) begin
        r_req_cnt <= '0;
      end
      if (w_accept) begin
        r_out      <= 1'b0;
        r_buf      <= w_pix_color;
        r_buf_full <= 1'b1;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end else if (w_buf_pop) begin
        r_buf_full <= 1'b0;
      end
      if (w_buf_pop) r_lo_byte <= r_buf[7:0];
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] r_tmo;
  logic          r_err;

  assign w_tmo       = r_out && !i_done && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_pix_color = w_done_in ? i_done_color : 16'h0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= r_out ? r_tmo + 1'b1 : '0;
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign o_err_timeout = r_err;
`else
  assign w_tmo         = 1'b0;
  assign w_pix_color   = i_done_color;
  // Without the timeout build the flag is constant low; TIMEOUT_CYC has no effect.
  assign o_err_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_tx_start),
    .i_byte      (w_tx_byte),
    .i_dc        (w_tx_dc),
    .o_busy      (w_tx_busy),
    .o_byte_done (w_tx_done),
    .o_sclk      (o_lcd_sclk),
    .o_mosi      (o_lcd_mosi),
    .o_dc_out    (o_lcd_dc)
  );

  assign o_update     = r_update;
  assign o_update_x   = r_x;
  assign o_update_y   = r_y;
  assign o_lcd_cs     = (r_state == StIdle) || (r_state == StGap);
  assign o_frame_done = (r_state == StGap);

endmodule
